gates_bist: RTL

- Hardware stimulus generator and response checker for the two-input combinational gates block.
- Drives the A/B inputs of the gates block through all four input combinations, waits for the outputs to settle, and samples the seven gate outputs.
- Compares each sample against internally computed expected values and reports a pass/fail summary.
- Sits beside the gates block as its self-test controller: gates feeds it results, it feeds gates stimulus.

---
 rtl/gates_bist.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gates_bist.sv
// gates_bist: built-in self-test controller for the two-input gates block.
// Sweeps A/B through patterns 0..3 (a = p[1], b = p[0]) for LOOPS sweeps,
// waits SETTLE_CYCLES after each drive, compares the seven gate results
// against locally computed expected values and keeps sticky error flags.
// Optional build macro GATES_BIST_STOP_ON_FAIL_EN: end the run at the first
// CHECK that sees any mismatch, so exactly one failing pattern is recorded.
module gates_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,  // 1..15
  parameter int unsigned LOOPS         = 1   // 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [6:0] res_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [3:0] fail_vec,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  state_t     r_state;
  logic [1:0] r_pat;
  logic [7:0] r_loop;
  logic [3:0] r_settle;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [6:0] r_err_mask;
  logic [3:0] r_fail_vec;
  logic [7:0] r_err_count;

  logic [6:0] w_expected;
  logic [6:0] w_mismatch;
  logic [6:0] w_err_mask_nxt;
  logic       w_any_mismatch;
  logic       w_last_pattern;
  logic       w_finish;

  // Expected gate outputs for the pattern currently on a_out/b_out,
  // bit order {Xnor, Not, Xor, Nand, Nor, Or, And}.
  assign w_expected = {~(r_a ^ r_b), ~r_a, r_a ^ r_b, ~(r_a & r_b),
                       ~(r_a | r_b), r_a | r_b, r_a & r_b};

  assign w_mismatch     = res_in ^ w_expected;
  assign w_err_mask_nxt = r_err_mask | w_mismatch;
  assign w_any_mismatch = |w_mismatch;
  assign w_last_pattern = (r_pat == 2'd3) && (r_loop == LOOP_LAST);

`ifdef GATES_BIST_STOP_ON_FAIL_EN
  assign w_finish = w_last_pattern || w_any_mismatch;
`else
  assign w_finish = w_last_pattern;
`endif

  // Run-control FSM with registered stimulus and result outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the order of statements change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pat       <= 2'd0;
      r_loop      <= 8'd0;
      r_settle    <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_mask  <= 7'd0;
      r_fail_vec  <= 4'd0;
      r_err_count <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_err_mask  <= 7'd0;
            r_fail_vec  <= 4'd0;
            r_err_count <= 8'd0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_pat       <= 2'd0;
            r_loop      <= 8'd0;
            r_busy      <= 1'b1;
            r_state     <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          r_a      <= r_pat[1];
          r_b      <= r_pat[0];
          r_settle <= 4'd0;
          r_state  <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end

        ST_CHECK: begin
          r_err_mask <= w_err_mask_nxt;
          if (w_any_mismatch) begin
            r_fail_vec[r_pat] <= 1'b1;
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
          if (w_finish) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_mask_nxt == 7'd0);
            r_state <= ST_DONE;
          end else begin
            r_pat <= r_pat + 2'd1;
            if (r_pat == 2'd3) begin
              r_loop <= r_loop + 8'd1;
            end
            r_state <= ST_DRIVE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_mask  = r_err_mask;
  assign fail_vec  = r_fail_vec;
  assign err_count = r_err_count;

endmodule
